dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 36 +++
 rtl/dmem_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Pipeline-side and bus-side signal bundle for dmem_ctrl.
// master = the controller itself; slave = the pipeline plus bus/memory it talks to.
interface dmem_ctrl_if;
    logic [31:0] d_mem_addr_i;
    logic [31:0] d_mem_wdata_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic        stall_o;
    logic [31:0] mem_rdata_o;
    logic        rdata_valid_o;
    logic        misaligned_o;
    logic        bus_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    modport master (
        input  d_mem_addr_i, d_mem_wdata_i, mem_read_i, mem_write_i, funct3_i,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        output stall_o, mem_rdata_o, rdata_valid_o, misaligned_o, bus_err_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
    );

    modport slave (
        output d_mem_addr_i, d_mem_wdata_i, mem_read_i, mem_write_i, funct3_i,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        input  stall_o, mem_rdata_o, rdata_valid_o, misaligned_o, bus_err_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller: sized/aligned loads and stores over a req/gnt/rvalid bus.
// Optional bus-wait timeout is compiled in when DMEM_TIMEOUT_EN is defined.
module dmem_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.master dm
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;

    logic        req_present;
    logic        illegal;
    logic        tmo_fire;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] lane;
    logic [31:0] load_fmt;
    logic        stall;
    logic        misaligned;
    logic        bus_req;
    logic        rd_valid;

    assign req_present = dm.mem_read_i | dm.mem_write_i;

    always_comb begin
        illegal = 1'b0;
        case (dm.funct3_i)
            3'b001, 3'b101:         illegal = dm.d_mem_addr_i[0];
            3'b010:                 illegal = |dm.d_mem_addr_i[1:0];
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            default:                illegal = 1'b0;
        endcase
    end

    // Store lanes are replicated so the bus side only needs the byte enables.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = dm.d_mem_wdata_i;
        if (dm.mem_write_i) begin
            case (dm.funct3_i[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << dm.d_mem_addr_i[1:0];
                    st_wdata = {4{dm.d_mem_wdata_i[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << {dm.d_mem_addr_i[1], 1'b0};
                    st_wdata = {2{dm.d_mem_wdata_i[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = dm.d_mem_wdata_i;
                end
            endcase
        end
    end

    always_comb begin
        lane     = dm.bus_rdata_i >> {addr_q[1:0], 3'b000};
        load_fmt = lane;
        case (funct3_q)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'b0, lane[7:0]};
            3'b101:  load_fmt = {16'b0, lane[15:0]};
            default: load_fmt = lane;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        stall      = 1'b0;
        misaligned = 1'b0;
        bus_req    = 1'b0;
        rd_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_present) begin
                    if (illegal) begin
                        misaligned = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        state_d  = REQ;
                        addr_d   = dm.d_mem_addr_i;
                        funct3_d = dm.funct3_i;
                        we_d     = dm.mem_write_i;
                        be_d     = st_be;
                        wdata_d  = st_wdata;
                    end
                end
            end
            REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (dm.bus_gnt_i) begin
                    state_d = we_q ? DONE : WAIT;
                end else if (tmo_fire) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = '0;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dm.bus_rvalid_i) begin
                    rdata_d = load_fmt;
                    state_d = DONE;
                end else if (tmo_fire) begin
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Always return to IDLE so the still-presented request is not reissued.
                rd_valid = ~we_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            be_q     <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            be_q     <= be_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    // Clearing while idle means the count always restarts on entry to REQ.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tmo_fire = (cnt_q == CW'(TIMEOUT - 1)) &&
                      (((state_q == REQ) && !dm.bus_gnt_i) ||
                       ((state_q == WAIT) && !dm.bus_rvalid_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= tmo_fire;
        end
    end

    assign dm.bus_err_o = err_q;
`else
    assign tmo_fire     = 1'b0;
    assign dm.bus_err_o = 1'b0;
`endif

    assign dm.stall_o       = stall;
    assign dm.misaligned_o  = misaligned;
    assign dm.rdata_valid_o = rd_valid;
    assign dm.mem_rdata_o   = rdata_q;
    assign dm.bus_req_o     = bus_req;
    assign dm.bus_we_o      = we_q;
    assign dm.bus_addr_o    = {addr_q[31:2], 2'b00};
    assign dm.bus_wdata_o   = wdata_q;
    assign dm.bus_be_o      = be_q;
endmodule
